// File: rtl/sync_fifo_ext.sv
// Synchronous FIFO with occupancy count, almost-full/empty thresholds,
// overflow/underflow pulses and a choice of registered-read or FWFT output.
module sync_fifo_ext #(
  parameter int DEPTH    = 16,
  parameter int WIDTH    = 8,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr,
  input  logic [WIDTH-1:0]         din,
  input  logic                     rd,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0] C_AF    = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] C_AE    = (AW+1)'(AE_LEVEL);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             r_overflow;
  logic             r_underflow;

  logic w_full;
  logic w_empty;
  logic w_wr_ok;
  logic w_rd_ok;

  // Status is decoded from the registered count, so it tracks count exactly.
  assign w_full  = (r_count == C_DEPTH);
  assign w_empty = (r_count == '0);
  // Reset discards same-cycle requests; a full FIFO refuses writes even
  // when a read frees a slot on the same edge.
  assign w_wr_ok = wr & ~w_full & ~rst;
  assign w_rd_ok = rd & ~w_empty & ~rst;

  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem[r_wptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_ok) r_wptr <= r_wptr + 1'b1;
      if (w_rd_ok) r_rptr <= r_rptr + 1'b1;
      case ({w_wr_ok, w_rd_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_overflow  <= wr & w_full;
      r_underflow <= rd & w_empty;
    end
  end

  generate
    if (FWFT == 0) begin : g_reg_read
      logic [WIDTH-1:0] r_dout;
      always_ff @(posedge clk) begin
        if (rst) begin
          r_dout <= '0;
        end else if (w_rd_ok) begin
          r_dout <= r_mem[r_rptr];
        end
      end
      assign dout = r_dout;
    end else begin : g_fwft
      // Head entry is shown combinationally so a fresh write appears one edge later.
      assign dout = w_empty ? '0 : r_mem[r_rptr];
    end
  endgenerate

  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= C_AF);
  assign almost_empty = (r_count <= C_AE);
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_ext.sv
// Bench for sync_fifo_ext: one registered-read and one FWFT instance share
// stimulus and are compared against a queue-based reference model.
module tb_sync_fifo_ext;

  localparam int DEPTH = 16;
  localparam int WIDTH = 8;
  localparam int AF    = DEPTH - 2;
  localparam int AE    = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             wr  = 1'b0;
  logic             rd  = 1'b0;
  logic [WIDTH-1:0] din = '0;

  logic [WIDTH-1:0] dout0, dout1;
  logic             full0, empty0, af0, ae0, ovf0, unf0;
  logic             full1, empty1, af1, ae1, ovf1, unf1;
  logic [4:0]       count0, count1;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] m_dout0;
  logic             m_ovf, m_unf;

  always #5 clk = ~clk;

  sync_fifo_ext #(.DEPTH(DEPTH), .WIDTH(WIDTH), .FWFT(0)) u0 (
    .clk(clk), .rst(rst), .wr(wr), .din(din), .rd(rd), .dout(dout0),
    .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
    .count(count0), .overflow(ovf0), .underflow(unf0)
  );

  sync_fifo_ext #(.DEPTH(DEPTH), .WIDTH(WIDTH), .FWFT(1)) u1 (
    .clk(clk), .rst(rst), .wr(wr), .din(din), .rd(rd), .dout(dout1),
    .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
    .count(count1), .overflow(ovf1), .underflow(unf1)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] head_or_zero();
    if (q.size() == 0) return '0;
    return q[0];
  endfunction

  task automatic model_edge(input logic r, input logic w, input logic d_rd, input logic [WIDTH-1:0] d);
    int n;
    n = q.size();
    if (r) begin
      q.delete();
      m_dout0 = '0;
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
    end else begin
      m_ovf = w && (n == DEPTH);
      m_unf = d_rd && (n == 0);
      if (d_rd && n != 0) m_dout0 = q.pop_front();
      if (w && n != DEPTH) q.push_back(d);
    end
  endtask

  task automatic check_model();
    int n;
    n = q.size();
    chk("count",        int'(count0), n);
    chk("full",         int'(full0),  int'(n == DEPTH));
    chk("empty",        int'(empty0), int'(n == 0));
    chk("almost_full",  int'(af0),    int'(n >= AF));
    chk("almost_empty", int'(ae0),    int'(n <= AE));
    chk("overflow",     int'(ovf0),   int'(m_ovf));
    chk("underflow",    int'(unf0),   int'(m_unf));
    chk("dout_reg",     int'(dout0),  int'(m_dout0));
    chk("count_fwft",   int'(count1), n);
    chk("dout_fwft",    int'(dout1),  int'(head_or_zero()));
  endtask

  // One clock: present inputs, take the edge, update model, sample #1 later.
  task automatic step(input logic r, input logic w, input logic d_rd, input logic [WIDTH-1:0] d);
    rst = r; wr = w; rd = d_rd; din = d;
    @(posedge clk);
    model_edge(r, w, d_rd, d);
    #1;
    check_model();
    $display("txn rst=%0b wr=%0b rd=%0b din=%02h -> count=%0d dout=%02h fwft=%02h ovf=%0b unf=%0b",
             r, w, d_rd, d, count0, dout0, dout1, ovf0, unf0);
  endtask

  typedef struct {
    logic             rst, wr, rd;
    logic [WIDTH-1:0] din;
    int               e_count;
    logic             e_empty, e_ovf, e_unf;
    logic [WIDTH-1:0] e_dout0, e_dout1;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 8'hA1, 1, 1'b0, 1'b0, 1'b0, 8'h00, 8'hA1};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 8'hB2, 2, 1'b0, 1'b0, 1'b0, 8'h00, 8'hA1};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 8'h00, 1, 1'b0, 1'b0, 1'b0, 8'hA1, 8'hB2};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 8'hC3, 1, 1'b0, 1'b0, 1'b0, 8'hB2, 8'hC3};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b0, 1'b0, 8'hC3, 8'h00};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b0, 1'b1, 8'hC3, 8'h00};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 8'hD4, 1, 1'b0, 1'b0, 1'b0, 8'hC3, 8'hD4};
    vecs[8] = '{1'b1, 1'b1, 1'b0, 8'h55, 0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00};
    vecs[9] = '{1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00};

    q.delete();
    m_dout0 = '0; m_ovf = 1'b0; m_unf = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < 10; i++) begin
      step(vecs[i].rst, vecs[i].wr, vecs[i].rd, vecs[i].din);
      chk("vec_count", int'(count0), vecs[i].e_count);
      chk("vec_empty", int'(empty0), int'(vecs[i].e_empty));
      chk("vec_ovf",   int'(ovf0),   int'(vecs[i].e_ovf));
      chk("vec_unf",   int'(unf0),   int'(vecs[i].e_unf));
      chk("vec_dout",  int'(dout0),  int'(vecs[i].e_dout0));
      chk("vec_fwft",  int'(dout1),  int'(vecs[i].e_dout1));
    end

    // Fill 16 words, watching almost_full and full
    step(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b1, 1'b0, 8'(i));
      if (i == 12) chk("af_at_13", int'(af0), 0);
      if (i == 13) chk("af_at_14", int'(af0), 1);
    end
    chk("full_16", int'(full0), 1);
    chk("count_16", int'(count0), 16);
    step(1'b0, 1'b1, 1'b0, 8'hEE);
    chk("ovf_pulse", int'(ovf0), 1);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    chk("ovf_clear", int'(ovf0), 0);

    // Drain in order, then one extra read
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b0, 1'b1, 8'h00);
      chk("drain_dout", int'(dout0), i);
    end
    chk("empty_after_drain", int'(empty0), 1);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    chk("unf_pulse", int'(unf0), 1);
    chk("dout_hold", int'(dout0), 8'h0F);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    chk("unf_clear", int'(unf0), 0);

    // Simultaneous read/write at count=5 across pointer wrap
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h40 + i));
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, 1'b1, 8'(8'h50 + i));
      chk("rw_count5", int'(count0), 5);
    end

    // FWFT single word into empty
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 8'hA5);
    chk("fwft_a5", int'(dout1), 8'hA5);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    chk("fwft_empty", int'(empty1), 1);
    chk("fwft_zero", int'(dout1), 0);

    // Reset with a concurrent write at count=9
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h90 + i));
    step(1'b1, 1'b1, 1'b0, 8'h33);
    chk("rst_count", int'(count0), 0);
    chk("rst_empty", int'(empty0), 1);
    chk("rst_dout", int'(dout0), 0);
    step(1'b0, 1'b1, 1'b0, 8'h77);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    chk("post_rst_data", int'(dout0), 8'h77);

    // Read and write together while full
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, 8'(8'hC0 + i));
    step(1'b0, 1'b1, 1'b1, 8'hFF);
    chk("full_rw_count", int'(count0), 15);
    chk("full_rw_ovf", int'(ovf0), 1);
    chk("full_rw_dout", int'(dout0), 8'hC0);

    // Randomised traffic with shifting write/read bias
    for (int i = 0; i < 3000; i++) begin
      int wbias;
      wbias = ((i / 200) % 2 == 0) ? 70 : 30;
      step($urandom_range(0, 299) == 0,
           $urandom_range(0, 99) < wbias,
           $urandom_range(0, 99) < (100 - wbias),
           8'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
